// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline/hazard-controller signal bundle
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        branch_take;
    logic [31:0] branch_target;
    logic        imem_resp;
    logic        dmem_req;
    logic        dmem_resp;
    logic        pc_load;
    logic        if_id_load;
    logic        id_ex_load;
    logic        ex_mem_load;
    logic        mem_wb_load;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
               branch_take, branch_target, imem_resp, dmem_req, dmem_resp,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, redirect_valid, redirect_pc,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
               branch_take, branch_target, imem_resp, dmem_req, dmem_resp,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, redirect_valid, redirect_pc,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush/redirect controller
module pipeline_hazard_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] DISCARD = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [31:0] redir_reg, redir_nxt;
    logic [31:0] stall_cnt, flush_cnt;
    logic        stall_inc, flush_inc;
    logic        freeze, load_use, rs1_hit, rs2_hit;

    logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic        if_id_flush, id_ex_flush, redirect_valid;
    logic [31:0] redirect_pc;

    assign freeze   = bus.dmem_req & ~bus.dmem_resp;
    assign rs1_hit  = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd);
    assign rs2_hit  = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd);
    assign load_use = bus.ex_is_load & (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        pc_load        = 1'b1;
        if_id_load     = 1'b1;
        id_ex_load     = 1'b1;
        ex_mem_load    = 1'b1;
        mem_wb_load    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        state_nxt      = state;
        redir_nxt      = redir_reg;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (freeze) begin
            // A blocked data access holds every stage, including any pending redirect.
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_load  = 1'b0;
            ex_mem_load = 1'b0;
            mem_wb_load = 1'b0;
            stall_inc   = 1'b1;
        end else if (state == DISCARD) begin
            // Waiting for the wrong-path fetch to return; ID/EX carries only bubbles.
            pc_load     = bus.imem_resp;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (bus.imem_resp) begin
                redirect_valid = 1'b1;
                redirect_pc    = redir_reg;
                state_nxt      = RUN;
            end
        end else if (bus.branch_take) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
            if (bus.imem_resp) begin
                redirect_valid = 1'b1;
                redirect_pc    = bus.branch_target;
            end else begin
                // Fetch still in flight: park the target until it completes.
                pc_load   = 1'b0;
                redir_nxt = bus.branch_target;
                state_nxt = DISCARD;
            end
        end else if (load_use) begin
            pc_load     = 1'b0;
            if_id_load  = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end else if (!bus.imem_resp) begin
            pc_load     = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            redir_reg <= 32'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            state     <= state_nxt;
            redir_reg <= redir_nxt;
            if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
            if (flush_inc) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.pc_load        = pc_load;
    assign bus.if_id_load     = if_id_load;
    assign bus.id_ex_load     = id_ex_load;
    assign bus.ex_mem_load    = ex_mem_load;
    assign bus.mem_wb_load    = mem_wb_load;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.stall_cycles   = stall_cnt;
    assign bus.flush_count    = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized and directed bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference state: is a redirect pending, to where, and the two event tallies.
    bit          pend = 1'b0;
    logic [31:0] pend_pc = 32'd0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit is_freeze();
        return bus.dmem_req && !bus.dmem_resp;
    endfunction

    function automatic bit is_load_use();
        bit hit1, hit2;
        hit1 = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
        hit2 = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
        return bus.ex_is_load && (bus.ex_rd != 0) && (hit1 || hit2);
    endfunction

    // Expected outputs: loads packed {pc, if_id, id_ex, ex_mem, mem_wb}.
    task automatic model_out(output logic [4:0] ld, output logic fl_if, output logic fl_ex,
                             output logic rv, output logic [31:0] rpc);
        ld = 5'b11111; fl_if = 0; fl_ex = 0; rv = 0; rpc = 0;
        if (is_freeze()) begin
            ld = 5'b00000;
        end else if (pend) begin
            fl_if = 1; fl_ex = 1;
            ld[4] = bus.imem_resp;
            if (bus.imem_resp) begin rv = 1; rpc = pend_pc; end
        end else if (bus.branch_take) begin
            fl_if = 1; fl_ex = 1;
            if (bus.imem_resp) begin rv = 1; rpc = bus.branch_target; end
            else ld[4] = 0;
        end else if (is_load_use()) begin
            ld[4] = 0; ld[3] = 0; fl_ex = 1;
        end else if (!bus.imem_resp) begin
            ld[4] = 0; fl_if = 1;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend = 0; pend_pc = 0; exp_stall = 0; exp_flush = 0;
        end else begin
            if (is_freeze() || (!pend && !bus.branch_take && is_load_use())) exp_stall = exp_stall + 1;
            if (!is_freeze() && !pend && bus.branch_take) exp_flush = exp_flush + 1;
            if (!is_freeze()) begin
                if (pend && bus.imem_resp) pend = 0;
                else if (!pend && bus.branch_take && !bus.imem_resp) begin
                    pend = 1; pend_pc = bus.branch_target;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0]  ld;
        logic        fl_if, fl_ex, rv;
        logic [31:0] rpc;
        #2;
        if (cmp_en) begin
            model_out(ld, fl_if, fl_ex, rv, rpc);
            chk("loads", 32'({bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load, bus.mem_wb_load}), 32'(ld));
            chk("if_id_flush", 32'(bus.if_id_flush), 32'(fl_if));
            chk("id_ex_flush", 32'(bus.id_ex_flush), 32'(fl_ex));
            chk("redirect_valid", 32'(bus.redirect_valid), 32'(rv));
            chk("redirect_pc", bus.redirect_pc, rpc);
            chk("stall_cycles", bus.stall_cycles, exp_stall);
            chk("flush_count", bus.flush_count, exp_flush);
        end
    end

    task automatic idle();
        bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.ex_rd = 5'd0; bus.ex_is_load = 0; bus.branch_take = 0; bus.branch_target = 32'd0;
        bus.imem_resp = 1; bus.dmem_req = 0; bus.dmem_resp = 0;
    endtask

    task automatic br(input logic [31:0] tgt, input logic imem);
        idle(); bus.branch_take = 1; bus.branch_target = tgt; bus.imem_resp = imem;
    endtask

    initial begin
        idle();
        cmp_en = 1;
        @(negedge clk); @(negedge clk);
        rst = 1;
        #3;
        chk("reset stall", bus.stall_cycles, 32'd0);
        chk("reset flush", bus.flush_count, 32'd0);
        chk("idle pc_load", 32'(bus.pc_load), 32'd1);

        @(negedge clk);
        idle(); bus.ex_is_load = 1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1;
        #3;
        chk("lu pc_load", 32'(bus.pc_load), 32'd0);
        chk("lu if_id_load", 32'(bus.if_id_load), 32'd0);
        chk("lu id_ex_flush", 32'(bus.id_ex_flush), 32'd1);

        @(negedge clk);
        bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
        #3;
        chk("lu stall +1", bus.stall_cycles, 32'd1);
        chk("rd0 pc_load", 32'(bus.pc_load), 32'd1);
        chk("rd0 if_id_load", 32'(bus.if_id_load), 32'd1);

        @(negedge clk);
        br(32'h6000_0040, 1);
        #3;
        chk("br redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("br redirect_pc", bus.redirect_pc, 32'h6000_0040);
        chk("br flushes", 32'({bus.if_id_flush, bus.id_ex_flush}), 32'd3);

        @(negedge clk);
        br(32'h6000_0100, 0);
        #3;
        chk("br flush +1", bus.flush_count, 32'd1);
        chk("brw pc_load", 32'(bus.pc_load), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle(); bus.imem_resp = 0;
            #3;
            chk("discard pc_load", 32'(bus.pc_load), 32'd0);
            chk("discard id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        end
        @(negedge clk);
        idle();
        #3;
        chk("discard fire pc_load", 32'(bus.pc_load), 32'd1);
        chk("discard fire pc", bus.redirect_pc, 32'h6000_0100);
        chk("discard fire if_id_flush", 32'(bus.if_id_flush), 32'd1);
        @(negedge clk);
        idle();
        #3;
        chk("back to run", 32'({bus.redirect_valid, bus.id_ex_flush}), 32'd0);
        chk("flush after discard", bus.flush_count, 32'd2);

        @(negedge clk);
        br(32'h6000_0200, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle(); bus.dmem_req = 1;
            #3;
            chk("freeze loads", 32'({bus.pc_load, bus.mem_wb_load, bus.redirect_valid}), 32'd0);
        end
        @(negedge clk);
        idle(); bus.dmem_req = 1; bus.dmem_resp = 1;
        #3;
        chk("freeze stall +4", bus.stall_cycles, 32'd5);
        chk("post-freeze redirect", bus.redirect_pc, 32'h6000_0200);
        chk("post-freeze flush", bus.flush_count, 32'd3);

        @(negedge clk);
        idle(); bus.dmem_req = 1;
        force dut.stall_cnt = 32'hFFFF_FFFF;
        exp_stall = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt;
        #2;
        chk("stall preset", bus.stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk);
        br(32'h1234_5678, 1);
        force dut.flush_cnt = 32'hFFFF_FFFF;
        exp_flush = 32'hFFFF_FFFF;
        #1 release dut.flush_cnt;
        #2;
        chk("stall wrap", bus.stall_cycles, 32'd0);
        @(negedge clk);
        idle();
        #3;
        chk("flush wrap", bus.flush_count, 32'd0);

        @(negedge clk);
        br(32'h6000_0300, 0);
        @(negedge clk);
        idle(); bus.imem_resp = 0; rst = 0;
        #3;
        chk("rst stall", bus.stall_cycles, 32'd0);
        chk("rst id_ex_flush", 32'(bus.id_ex_flush), 32'd0);
        @(negedge clk);
        idle(); rst = 1;
        #3;
        chk("rst abandons redirect", 32'(bus.redirect_valid), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) != 0);
            bus.id_rs1 = 5'($urandom_range(0, 3));
            bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.id_uses_rs1 = 1'($urandom_range(0, 1));
            bus.id_uses_rs2 = 1'($urandom_range(0, 1));
            bus.ex_is_load = 1'($urandom_range(0, 1));
            bus.branch_take = ($urandom_range(0, 4) == 0);
            bus.branch_target = $urandom;
            bus.imem_resp = ($urandom_range(0, 9) < 6);
            bus.dmem_req = ($urandom_range(0, 9) < 3);
            bus.dmem_resp = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1; idle();
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have the ports `id_rs1`, `id_rs2`, inputs, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have the ports `id_uses_rs1`, `id_uses_rs2`, inputs, 1 bit each: the ID instruction reads that source.
REQ-005 The block SHALL have the ports `ex_rd` (input, 5 bits) and `ex_is_load` (input, 1 bit): destination of the EX instruction, and whether that instruction is a load.
REQ-006 The block SHALL have the ports `branch_take` (input, 1 bit) and `branch_target` (input, 32 bits): the EX branch/jump redirects, and its target.
REQ-007 The block SHALL have the port `imem_resp`, input, 1 bit: fetch data valid; held high until a cycle with `pc_load`=1.
REQ-008 The block SHALL have the ports `dmem_req` and `dmem_resp`, inputs, 1 bit each: a MEM-stage access is outstanding, and it completes this cycle.
REQ-009 The block SHALL have the ports `pc_load`, `if_id_load`, `id_ex_load`, `ex_mem_load`, `mem_wb_load`, outputs, 1 bit each: per-stage register enables.
REQ-010 The block SHALL have the ports `if_id_flush` and `id_ex_flush`, outputs, 1 bit each: load a bubble (all-zero control word) instead of the data.
REQ-011 The block SHALL have the ports `redirect_valid` (output, 1 bit) and `redirect_pc` (output, 32 bits): the PC mux selects `redirect_pc` when `redirect_valid`=1.
REQ-012 The block SHALL have the ports `stall_cycles` and `flush_count`, outputs, 32 bits each: performance counters.

Function
REQ-013 The block SHALL implement an FSM with states RUN and DISCARD, plus a 32-bit register `redir_reg`.
REQ-014 The block SHALL define freeze = `dmem_req` & ~`dmem_resp`.
- All five load enables are 0; both flushes are 0; `redirect_valid`=0.
- The FSM state and `redir_reg` are held.
- Freeze has top priority.
REQ-015 RUN with no freeze and `branch_take`=1 and `imem_resp`=1:
- `pc_load`=1, `redirect_valid`=1, `redirect_pc`=`branch_target`.
- All loads are 1; `if_id_flush`=1 and `id_ex_flush`=1.
- The FSM stays in RUN.
REQ-016 RUN with no freeze and `branch_take`=1 and `imem_resp`=0:
- `redir_reg`<=`branch_target`; the next state is DISCARD.
- `pc_load`=0; the other loads are 1; both flushes are 1.
REQ-017 DISCARD with no freeze:
- `pc_load`=`imem_resp`; the other loads are 1; both flushes are 1.
- When `imem_resp`=1, `redirect_valid`=1 and `redirect_pc`=`redir_reg`, and the next state is RUN.
- `branch_take` is ignored in DISCARD, because ID/EX holds only bubbles.
REQ-018 The block SHALL define load-use = `ex_is_load` & (`ex_rd`!=0) & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
REQ-019 RUN with no freeze, no `branch_take` and load-use:
- `pc_load`=0, `if_id_load`=0.
- `id_ex_load`=1, `id_ex_flush`=1; EX/MEM and MEM/WB loads are 1.
REQ-020 RUN with no freeze, no branch, no load-use and `imem_resp`=0:
- `pc_load`=0, `if_id_load`=1, `if_id_flush`=1.
- The downstream loads are 1.
REQ-021 RUN with no hazard and `imem_resp`=1: all loads are 1, flushes are 0, `redirect_valid`=0.
REQ-022 Priority SHALL be freeze > branch > load-use > imem stall.
REQ-023 All outputs except the counters and `redirect_pc` (when `redirect_valid`=1) SHALL be combinational from the inputs and state.
- Latency from `imem_resp` in DISCARD to the PC update is 0 cycles.
REQ-024 `stall_cycles` SHALL increment by 1 in each cycle where freeze or load-use (REQ-019) applies.
REQ-025 `flush_count` SHALL increment by 1 in each cycle where REQ-015 or REQ-016 applies.
REQ-026 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-027 `redirect_pc` SHALL be 0 when `redirect_valid`=0.

Reset
REQ-028 When `rst`=0, the block SHALL asynchronously set: state=RUN, `redir_reg`=0, `stall_cycles`=0, `flush_count`=0.
REQ-029 During reset, outputs SHALL follow the RUN equations with zeroed registers. No counter increments while `rst`=0.
REQ-030 A reset asserted in DISCARD SHALL abandon the pending redirect. The first cycle after release is RUN.

Verification
REQ-031 `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1, `imem_resp`=1 -> `pc_load`=0, `if_id_load`=0, `id_ex_flush`=1, `stall_cycles` +1.
REQ-032 Same as REQ-031 but `ex_rd`=0 -> no stall; all loads are 1.
REQ-033 RUN, `branch_take`=1, `branch_target`=0x60000040, `imem_resp`=1 -> `redirect_valid`=1, `redirect_pc`=0x60000040, both flushes are 1, `flush_count` +1.
REQ-034 RUN, `branch_take`=1, target 0x60000100, `imem_resp`=0 for 3 cycles then 1:
- Three cycles with `pc_load`=0, state DISCARD.
- Fourth cycle `pc_load`=1, `redirect_pc`=0x60000100, `if_id_flush`=1.
- Then RUN.
REQ-035 DISCARD with `dmem_req`=1, `dmem_resp`=0 for 4 cycles and `imem_resp`=1:
- All loads are 0 for 4 cycles; `stall_cycles` +4.
- On the `dmem_resp` cycle, the redirect fires as in REQ-017.
REQ-036 `stall_cycles` preset to 0xFFFFFFFF via a long freeze, one more freeze cycle -> 0. `rst` pulsed low mid-DISCARD -> RUN, counters 0.
